// File: rtl/aes_inv_key_expander.sv
// ---------------------------------------------------------------------------
// AES_sbox
//   Forward AES substitution box, one byte in, one byte out, purely
//   combinational table lookup.
//   Ports:
//     data_i  in   8   byte to substitute
//     data_o  out  8   S-box image of data_i
// ---------------------------------------------------------------------------
module AES_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data_o = SBOX[data_i];

endmodule

// ---------------------------------------------------------------------------
// aes_inv_key_expander
//   Iterative AES-128 inverse key schedule. Loads the round-10 key and walks
//   the schedule backwards one round per cycle, streaming round keys
//   10, 9, ..., 0 over a valid/ready interface for the inverse cipher.
//   Ports:
//     clk            in   1    clock, all state on rising edge
//     reset          in   1    asynchronous active-high reset
//     key_in         in   128  round-10 key, first word in [127:96]
//     key_in_valid   in   1    key_in valid
//     key_in_ready   out  1    idle, a new key can be accepted
//     key_out        out  128  current round key, same word order as key_in
//     key_out_round  out  4    round index of key_out
//     key_out_valid  out  1    key_out / key_out_round valid
//     key_out_ready  in   1    consumer accepts key_out
//     busy           out  1    sequence in progress
// ---------------------------------------------------------------------------
module aes_inv_key_expander #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         key_in_valid,
  output logic         key_in_ready,
  output logic [127:0] key_out,
  output logic [3:0]   key_out_round,
  output logic         key_out_valid,
  input  logic         key_out_ready,
  output logic         busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t       state_q;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic         valid_q;
  logic         in_ready_q;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [7:0]   rcon;
  logic [127:0] key_d;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Later words of the previous round fall out of neighbouring XORs; the
  // recovered last word p3 then feeds the g() function that rebuilds p0.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  assign rot_word = {p3[23:0], p3[31:24]};

  AES_sbox u_sbox0 (.data_i(rot_word[31:24]), .data_o(sub_word[31:24]));
  AES_sbox u_sbox1 (.data_i(rot_word[23:16]), .data_o(sub_word[23:16]));
  AES_sbox u_sbox2 (.data_i(rot_word[15:8]),  .data_o(sub_word[15:8]));
  AES_sbox u_sbox3 (.data_i(rot_word[7:0]),   .data_o(sub_word[7:0]));

  // Round constant belongs to the round being undone (the current one).
  always_comb begin
    rcon = 8'h00;
    unique case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign p0    = w0 ^ sub_word ^ {rcon, 24'h0};
  assign key_d = {p0, p1, p2, p3};

  // Every output comes straight from a register, so neither handshake input
  // has a combinational path to the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      key_q      <= '0;
      round_q    <= '0;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (key_in_valid) begin
            key_q      <= key_in;
            round_q    <= LAST_ROUND;
            valid_q    <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= EMIT;
          end
        end
        EMIT: begin
          if (key_out_ready) begin
            if (round_q != 4'd0) begin
              key_q   <= key_d;
              round_q <= round_q - 4'd1;
            end else begin
              valid_q    <= 1'b0;
              in_ready_q <= 1'b1;
              state_q    <= IDLE;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          valid_q    <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign key_out       = key_q;
  assign key_out_round = round_q;
  assign key_out_valid = valid_q;
  assign key_in_ready  = in_ready_q;
  assign busy          = ~in_ready_q;

endmodule

// File: tb/tb_aes_inv_key_expander.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_key_expander
//   Directed bench for the inverse AES-128 key schedule. Round keys are the
//   FIPS-197 A.1 expansion of 2b7e1516..09cf4f3c plus a few known keys of the
//   all-zero cipher key expansion.
// ---------------------------------------------------------------------------
module tb_aes_inv_key_expander;

  logic         clk;
  logic         reset;
  logic [127:0] key_in;
  logic         key_in_valid;
  logic         key_in_ready;
  logic [127:0] key_out;
  logic [3:0]   key_out_round;
  logic         key_out_valid;
  logic         key_out_ready;
  logic         busy;

  int vectors;
  int miscompares;

  logic [127:0] fips [0:10];

  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  aes_inv_key_expander #(.NUM_ROUNDS(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_in       (key_in),
    .key_in_valid (key_in_valid),
    .key_in_ready (key_in_ready),
    .key_out      (key_out),
    .key_out_round(key_out_round),
    .key_out_valid(key_out_valid),
    .key_out_ready(key_out_ready),
    .busy         (busy)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present a key for exactly one accepting cycle.
  task automatic applyStimulus(input logic [127:0] k);
    checkOutput("load_ready", {127'b0, key_in_ready}, 128'd1);
    key_in       = k;
    key_in_valid = 1'b1;
    step();
    key_in_valid = 1'b0;
  endtask

  // Check the currently presented round key, then move on one cycle.
  task automatic expectRound(input int r, input logic [127:0] k, input bit doCheckKey);
    checkOutput($sformatf("valid_r%0d", r), {127'b0, key_out_valid}, 128'd1);
    checkOutput($sformatf("round_r%0d", r), {124'b0, key_out_round}, 128'(r));
    if (doCheckKey)
      checkOutput($sformatf("key_r%0d", r), key_out, k);
    checkOutput($sformatf("inready_r%0d", r), {127'b0, key_in_ready}, 128'd0);
    checkOutput($sformatf("busy_r%0d", r), {127'b0, busy}, 128'd1);
    step();
  endtask

  task automatic expectIdle(input string tag);
    checkOutput({tag, "_valid"}, {127'b0, key_out_valid}, 128'd0);
    checkOutput({tag, "_inready"}, {127'b0, key_in_ready}, 128'd1);
    checkOutput({tag, "_busy"}, {127'b0, busy}, 128'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    reset         = 1'b1;
    key_in        = '0;
    key_in_valid  = 1'b0;
    key_out_ready = 1'b0;
    step();
    step();

    // Reset state
    expectIdle("rst");
    checkOutput("rst_key", key_out, 128'd0);
    checkOutput("rst_round", {124'b0, key_out_round}, 128'd0);
    reset = 1'b0;
    step();

    // key_out_ready while idle has no effect
    key_out_ready = 1'b1;
    step();
    expectIdle("idle_ready");

    // FIPS-197 A.1, ready held high: 11 consecutive valid cycles
    $display("[TB] FIPS-197 sequence");
    applyStimulus(fips[10]);
    for (int r = 10; r >= 0; r--) expectRound(r, fips[r], 1'b1);
    expectIdle("fips_end");

    // Backpressure at round 5 for 3 cycles
    $display("[TB] backpressure");
    applyStimulus(fips[10]);
    for (int r = 10; r >= 6; r--) expectRound(r, fips[r], 1'b1);
    key_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) expectRound(5, fips[5], 1'b1);
    key_out_ready = 1'b1;
    for (int r = 5; r >= 0; r--) expectRound(r, fips[r], 1'b1);
    expectIdle("bp_end");

    // Busy lockout: zero key pulsed during round 7 is ignored
    $display("[TB] busy lockout");
    applyStimulus(fips[10]);
    for (int r = 10; r >= 8; r--) expectRound(r, fips[r], 1'b1);
    key_in       = '0;
    key_in_valid = 1'b1;
    expectRound(7, fips[7], 1'b1);
    key_in_valid = 1'b0;
    for (int r = 6; r >= 0; r--) expectRound(r, fips[r], 1'b1);
    expectIdle("lock_end");

    // Reset in the middle of a sequence, then a clean reload
    $display("[TB] reset mid-sequence");
    applyStimulus(fips[10]);
    for (int r = 10; r >= 7; r--) expectRound(r, fips[r], 1'b1);
    checkOutput("pre_rst_round", {124'b0, key_out_round}, 128'd6);
    reset = 1'b1;
    step();
    expectIdle("midrst");
    checkOutput("midrst_key", key_out, 128'd0);
    reset = 1'b0;
    step();
    expectIdle("midrst_after");
    applyStimulus(fips[10]);
    for (int r = 10; r >= 0; r--) expectRound(r, fips[r], 1'b1);
    expectIdle("reload_end");

    // Back-to-back: second key accepted one cycle after the round-0 handshake
    $display("[TB] back-to-back");
    applyStimulus(fips[10]);
    for (int r = 10; r >= 0; r--) expectRound(r, fips[r], 1'b1);
    applyStimulus(ZERO_R10);
    expectRound(10, ZERO_R10, 1'b1);
    for (int r = 9; r >= 2; r--) expectRound(r, '0, 1'b0);
    expectRound(1, ZERO_R1, 1'b1);
    expectRound(0, 128'd0, 1'b1);
    expectIdle("b2b_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
